// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand beat in, result beat out.
// master = producer/consumer around the ALU, slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             cout;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, cin, sel, out_ready,
    input  in_ready, out_valid, result, result_hi, cout, zero, err
  );

  modport slave (
    input  in_valid, a, b, cin, sel, out_ready,
    output in_ready, out_valid, result, result_hi, cout, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit multi-cycle ALU (ADD, SUB, MUL, DIV, AND, OR, XOR, XNOR).
// MUL is shift-add and DIV is restoring division, one bit per cycle.
// Optional feature: define ALU_SEQ_DIV_EN to build the iterative divider;
// without it DIV completes in one cycle with err=1 and a zero result.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand beat
// BUSY  | iterating MUL/DIV, one bit per cycle
// DONE  | out_valid=1, registered result held until out_ready
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sel;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] r_acc;   // high product / partial remainder
  logic [WIDTH-1:0] r_lo;    // multiplier->low product / dividend->quotient
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_cout, r_zero, r_err;

  logic             w_accept, w_multi, w_last;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_res, w_res_hi;
  logic             w_cout, w_err;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_it_acc, w_it_lo;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST);
`ifdef ALU_SEQ_DIV_EN
  assign w_multi  = (bus.sel == OP_MUL) || ((bus.sel == OP_DIV) && (bus.b != '0));
`else
  assign w_multi  = (bus.sel == OP_MUL);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_multi ? S_BUSY : S_DONE;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // single-cycle results, computed straight from the operand beat
  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_cout   = 1'b0;
    w_err    = 1'b0;
    w_add    = '0;
    case (bus.sel)
      OP_ADD: begin
        w_add  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        w_res  = w_add[WIDTH-1:0];
        w_cout = w_add[WIDTH];
      end
      OP_SUB: begin
        w_add  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, bus.cin};
        w_res  = w_add[WIDTH-1:0];
        w_cout = w_add[WIDTH];
      end
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        // only reached as a single-cycle op when dividing by zero
        w_res    = '1;
        w_res_hi = bus.a;
`endif
        w_err    = 1'b1;
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      default: w_res = '0;
    endcase
  end

  assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0] w_div_sh, w_div_diff;
  logic           w_div_ok;
  assign w_div_sh   = {r_acc, r_lo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opa};
  assign w_div_ok   = ~w_div_diff[WIDTH];

  // one iteration step: shift-add for MUL, restoring step for DIV
  always_comb begin
    w_it_acc = w_mul_sum[WIDTH:1];
    w_it_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_sel == OP_DIV) begin
      w_it_acc = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_it_lo  = {r_lo[WIDTH-2:0], w_div_ok};
    end
  end
`else
  // one iteration step: shift-add for MUL (only iterative op without divider)
  always_comb begin
    w_it_acc = w_mul_sum[WIDTH:1];
    w_it_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_sel != OP_MUL) begin
      w_it_acc = r_acc;
      w_it_lo  = r_lo;
    end
  end
`endif

  // operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= OP_ADD;
      r_cnt       <= '0;
      r_opa       <= '0;
      r_acc       <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_sel <= bus.sel;
      r_cnt <= '0;
      r_acc <= '0;
      r_opa <= (bus.sel == OP_MUL) ? bus.a : bus.b;
      r_lo  <= (bus.sel == OP_MUL) ? bus.b : bus.a;
      if (!w_multi) begin
        r_result    <= w_res;
        r_result_hi <= w_res_hi;
        r_cout      <= w_cout;
        r_err       <= w_err;
        r_zero      <= (w_res == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_it_acc;
      r_lo  <= w_it_lo;
      if (w_last) begin
        r_cnt       <= '0;
        r_result    <= w_it_lo;
        r_result_hi <= w_it_acc;
        r_cout      <= 1'b0;
        r_err       <= 1'b0;
        r_zero      <= (w_it_lo == '0);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.cout      = r_cout;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16); expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  logic [W-1:0] held;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic);
    bus.sel = s; bus.a = ia; bus.b = ib; bus.cin = ic; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // latency in cycles from the accept edge to out_valid, bounded
  task automatic wait_valid(input int maxc, output int l);
    l = 1;
    while (!bus.out_valid && l < maxc) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic handshake;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] s, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ic, input int elat,
                        input logic [W-1:0] eres, input logic [W-1:0] ehi,
                        input logic ecout, input logic ezero, input logic eerr);
    int l;
    issue(s, ia, ib, ic);
    wait_valid(40, l);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".lat"}, 32'(l), 32'(elat));
    chk({tag, ".result"}, 32'(bus.result), 32'(eres));
    chk({tag, ".result_hi"}, 32'(bus.result_hi), 32'(ehi));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(ecout));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(ezero));
    chk({tag, ".err"}, 32'(bus.err), 32'(eerr));
    handshake;
    chk({tag, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.sel = 3'b000; bus.out_ready = 1'b0;

    #12;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.result_hi", 32'(bus.result_hi), 32'd0);
    chk("rst.flags", {29'd0, bus.cout, bus.zero, bus.err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("sub_borrow", 3'b001, 16'h0005, 16'h0007, 1'b1, 1, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_noborrow", 3'b001, 16'h0007, 16'h0005, 1'b1, 1, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("and", 3'b100, 16'h00FF, 16'h0F0F, 1'b1, 1, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'b101, 16'h00FF, 16'h0F0F, 1'b0, 1, 16'h0FFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("xor", 3'b110, 16'h00FF, 16'h0F0F, 1'b0, 1, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("xnor", 3'b111, 16'h00FF, 16'h0F0F, 1'b0, 1, 16'hF00F, 16'h0000, 1'b0, 1'b0, 1'b0);

    // in_ready must drop right after a MUL is accepted
    issue(3'b010, 16'h1234, 16'h0100, 1'b0);
    chk("mul.in_ready_busy", 32'(bus.in_ready), 32'd0);
    wait_valid(40, lat);
    chk("mul.lat", 32'(lat), 32'd17);
    chk("mul.result", 32'(bus.result), 32'h3400);
    chk("mul.result_hi", 32'(bus.result_hi), 32'h0012);
    handshake;

    run_op("mul_max", 3'b010, 16'hFFFF, 16'hFFFF, 1'b1, 17, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("mul_9x3", 3'b010, 16'd9, 16'd3, 1'b0, 17, 16'd27, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("mul_zero", 3'b010, 16'h0000, 16'h1234, 1'b0, 17, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

`ifdef ALU_SEQ_DIV_EN
    run_op("div_100_7", 3'b011, 16'd100, 16'd7, 1'b0, 17, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0);
    run_op("div_by0", 3'b011, 16'h0042, 16'h0000, 1'b0, 1, 16'hFFFF, 16'h0042, 1'b0, 1'b0, 1'b1);
    run_op("div_9_3", 3'b011, 16'd9, 16'd3, 1'b0, 17, 16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    run_op("div_small", 3'b011, 16'd5, 16'd9, 1'b0, 17, 16'd0, 16'd5, 1'b0, 1'b1, 1'b0);
`else
    run_op("div_off_9_3", 3'b011, 16'd9, 16'd3, 1'b0, 1, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    run_op("div_off_by0", 3'b011, 16'h0042, 16'h0000, 1'b0, 1, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
`endif

    // backpressure: result must hold while out_ready is low; new beats ignored
    issue(3'b000, 16'd3, 16'd5, 1'b0);
    wait_valid(40, lat);
    chk("bp.lat", 32'(lat), 32'd1);
    bus.sel = 3'b111; bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp.in_ready_hold", 32'(bus.in_ready), 32'd0);
      chk("bp.result_hold", 32'(bus.result), 32'd8);
    end
    bus.in_valid = 1'b0;
    handshake;
    chk("bp.in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp.valid_after", 32'(bus.out_valid), 32'd0);
    chk("bp.result_kept", 32'(bus.result), 32'd8);

    // out_ready already high when out_valid rises
    bus.out_ready = 1'b1;
    issue(3'b000, 16'd1, 16'd1, 1'b0);
    chk("early_rdy.valid", 32'(bus.out_valid), 32'd1);
    chk("early_rdy.result", 32'(bus.result), 32'd2);
    @(posedge clk); #1;
    chk("early_rdy.done", 32'(bus.out_valid), 32'd0);
    chk("early_rdy.in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // reset in the middle of a MUL
    issue(3'b010, 16'h1234, 16'h0100, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid.result", 32'(bus.result), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid.discarded", 32'(bus.out_valid), 32'd0);
    run_op("post_rst_add", 3'b000, 16'd3, 16'd4, 1'b0, 1, 16'd7, 16'd0, 1'b0, 1'b0, 1'b0);
    run_op("post_rst_mul", 3'b010, 16'h1234, 16'h0100, 1'b0, 17, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
